// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer for the single-cycle CPU: produces the per-cycle clock enable cpu_en.
// Breakpoint hardware is built only when RUN_CTRL_BP_EN is defined.
module cpu_run_ctrl #(
  parameter int unsigned DB_CYCLES = 125000,
  parameter int unsigned DB_W      = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_set,
  input  logic        bp_clr,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    StHalt  = 2'b00,
    StStep  = 2'b01,
    StRun   = 2'b10,
    StBreak = 2'b11
  } run_state_e;

  localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DbOne  = DB_W'(1);

  run_state_e      state_q;
  logic            run_meta;
  logic            run_s;
  logic            step_meta;
  logic            step_s;
  logic [DB_W-1:0] db_cnt;
  logic            step_db;
  logic            step_db_prev;
  logic            step_rise;
  logic            bp_hit;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
    end else begin
      run_meta  <= run;
      run_s     <= run_meta;
      step_meta <= step;
      step_s    <= step_meta;
    end
  end

  // step_db follows step_s only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt  <= '0;
      step_db <= 1'b0;
    end else if (step_s != step_db) begin
      if (db_cnt == DbLast) begin
        step_db <= step_s;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + DbOne;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Registered rising-edge pulse of the debounced button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_db_prev <= 1'b0;
      step_rise    <= 1'b0;
    end else begin
      step_db_prev <= step_db;
      step_rise    <= step_db & ~step_db_prev;
    end
  end

`ifdef RUN_CTRL_BP_EN
  logic [31:0] bp_reg;
  logic        bp_armed;

  // A simultaneous set and clear leaves the breakpoint armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_reg   <= '0;
      bp_armed <= 1'b0;
    end else if (bp_set) begin
      bp_reg   <= bp_addr;
      bp_armed <= 1'b1;
    end else if (bp_clr) begin
      bp_armed <= 1'b0;
    end
  end

  assign bp_hit = bp_armed & (pc == bp_reg);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_set, bp_clr};
  assign bp_hit    = 1'b0;
`endif

  // Combinational so that a breakpoint blocks the instruction at pc in the same cycle.
  assign cpu_en = (state_q == StStep) | ((state_q == StRun) & ~bp_hit);
  assign state  = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHalt;
      halted  <= 1'b1;
    end else begin
      case (state_q)
        StHalt: begin
          if (run_s) begin
            state_q <= StRun;
            halted  <= 1'b0;
          end else if (step_rise) begin
            state_q <= StStep;
            halted  <= 1'b0;
          end
        end
        StStep: begin
          state_q <= StHalt;
          halted  <= 1'b1;
        end
        StRun: begin
          if (!run_s) begin
            state_q <= StHalt;
            halted  <= 1'b1;
          end else if (bp_hit) begin
            state_q <= StBreak;
            halted  <= 1'b1;
          end
        end
        StBreak: begin
          if (!run_s) begin
            state_q <= StHalt;
            halted  <= 1'b1;
          end else if (step_rise) begin
            state_q <= StStep;
            halted  <= 1'b0;
          end
        end
        default: begin
          state_q <= StHalt;
          halted  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  halted_matches_state: assert property (@(posedge clk) disable iff (rst)
    halted == ((state_q == StHalt) || (state_q == StBreak)));

  no_enable_when_halted: assert property (@(posedge clk) disable iff (rst)
    halted |-> !cpu_en);

endmodule
